// File: rtl/pitch_pkg.sv
// Shared types and widths for the pitch period detector.
package pitch_pkg;

  typedef enum logic [0:0] {ARMING, TRACKING} pd_state_t;

  localparam int unsigned PERIOD_W = 12;
  localparam int unsigned ACC_W    = 14;
  localparam int unsigned SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

endpackage

// File: rtl/pitch_period_detect_if.sv
// Sample stream in from the oversampler, averaged period out to note matching.
interface pitch_period_detect_if;
  import pitch_pkg::*;

  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic [PERIOD_W-1:0] period_out;
  logic                period_valid;
  logic                silent;

  modport master (
    output sample, sample_valid,
    input  period_out, period_valid, silent
  );

  modport slave (
    input  sample, sample_valid,
    output period_out, period_valid, silent
  );

endinterface

// File: rtl/dc_tracker.sv
// Slow IIR baseline (time constant 2^DC_SHIFT samples) and bias-free AC value.
module dc_tracker
  import pitch_pkg::*;
#(
  parameter int unsigned DC_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [SAMPLE_W-1:0]        sample,
  output logic signed [SAMPLE_W:0]   ac,
  output logic                       ac_valid
);

  localparam int unsigned BASE_W = SAMPLE_W + DC_SHIFT;
  localparam logic [BASE_W-1:0] BASE_RST = BASE_W'(MIDSCALE) << DC_SHIFT;

  logic [BASE_W-1:0]         base_q;
  logic [SAMPLE_W-1:0]       base_int;
  logic signed [SAMPLE_W:0]  diff;

  assign base_int = base_q[BASE_W-1:DC_SHIFT];
  assign diff     = $signed({1'b0, sample}) - $signed({1'b0, base_int});

  // The same difference drives both the AC output and the baseline step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= BASE_RST;
      ac       <= '0;
      ac_valid <= 1'b0;
    end else begin
      ac_valid <= in_valid;
      if (in_valid) begin
        ac     <= diff;
        base_q <= base_q + BASE_W'(diff);
      end
    end
  end

endmodule

// File: rtl/pitch_period_detect.sv
// Rising zero-crossing period detector with hysteresis, averaging four periods.
module pitch_period_detect
  import pitch_pkg::*;
#(
  parameter int unsigned DC_SHIFT   = 8,
  parameter int unsigned HYST       = 64,
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned MAX_PERIOD = 4095
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pitch_period_detect_if.slave bus
);

  localparam logic signed [SAMPLE_W:0] HYST_S = (SAMPLE_W + 1)'(HYST);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

  logic                      sv_q;
  logic                      s0_vld_q;
  logic [SAMPLE_W-1:0]       sample_q;
  logic                      new_sample;
  logic signed [SAMPLE_W:0]  ac;
  logic                      ac_valid;

  pd_state_t                 state_q;
  logic                      pol_q, pol_d, crossing;
  logic [PERIOD_W-1:0]       cnt_q;
  logic [ACC_W-1:0]          acc_q;
  logic [1:0]                n_q;
  logic [ACC_W:0]            acc_sum, acc_rnd;
  logic [PERIOD_W-1:0]       period_out_q;
  logic                      period_valid_q, silent_q;

  assign new_sample = bus.sample_valid & ~sv_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sv_q     <= 1'b0;
      s0_vld_q <= 1'b0;
      sample_q <= MIDSCALE;
    end else begin
      sv_q     <= bus.sample_valid;
      s0_vld_q <= new_sample;
      if (new_sample) sample_q <= bus.sample;
    end
  end

  dc_tracker #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (s0_vld_q),
    .sample   (sample_q),
    .ac       (ac),
    .ac_valid (ac_valid)
  );

  always_comb begin
    pol_d = pol_q;
    if (ac > HYST_S)       pol_d = 1'b1;
    else if (ac < -HYST_S) pol_d = 1'b0;
  end

  assign crossing = pol_d & ~pol_q;
  assign acc_sum  = {1'b0, acc_q} + (ACC_W + 1)'(cnt_q);
  assign acc_rnd  = acc_sum + (ACC_W + 1)'(2);

  // Saturation is tested before the crossing so a crossing on that sample is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARMING;
      pol_q          <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      n_q            <= '0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      silent_q       <= 1'b1;
    end else begin
      period_valid_q <= 1'b0;
      if (ac_valid) begin
        pol_q <= pol_d;
        unique case (state_q)
          ARMING: begin
            if (crossing) begin
              cnt_q   <= PERIOD_W'(1);
              acc_q   <= '0;
              n_q     <= '0;
              state_q <= TRACKING;
            end
          end
          TRACKING: begin
            if (cnt_q == MAX_P) begin
              silent_q <= 1'b1;
              acc_q    <= '0;
              n_q      <= '0;
              state_q  <= ARMING;
            end else if (crossing && cnt_q >= MIN_P) begin
              cnt_q <= PERIOD_W'(1);
              if (n_q == 2'd3) begin
                period_out_q   <= acc_rnd[PERIOD_W+1:2];
                period_valid_q <= 1'b1;
                silent_q       <= 1'b0;
                acc_q          <= '0;
                n_q            <= '0;
              end else begin
                acc_q <= acc_sum[ACC_W-1:0];
                n_q   <= n_q + 2'd1;
              end
            end else begin
              cnt_q <= cnt_q + PERIOD_W'(1);
            end
          end
          default: state_q <= ARMING;
        endcase
      end
    end
  end

  assign bus.period_out   = period_out_q;
  assign bus.period_valid = period_valid_q;
  assign bus.silent       = silent_q;

endmodule

// File: tb/tb_pitch_period_detect.sv
// Directed bench for pitch_period_detect: square tones, bounce, noise, silence, reset.
module tb_pitch_period_detect;
  import pitch_pkg::*;

  localparam logic [15:0] HI    = 16'h83E8;  // mid + 1000
  localparam logic [15:0] LO    = 16'h7C18;  // mid - 1000
  localparam logic [15:0] SPIKE = 16'h7830;  // mid - 2000

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pitch_period_detect_if bus ();

  pitch_period_detect #(
    .DC_SHIFT   (8),
    .HYST       (64),
    .MIN_PERIOD (8),
    .MAX_PERIOD (4095)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int assertions = 0;
  int failures   = 0;
  int samp_idx, pulse_cnt, first_pv, last_pv;
  int pv_double = 0;
  logic pv_prev = 1'b0;

  always @(negedge clk) begin
    pv_prev <= bus.period_valid;
    if (bus.period_valid && pv_prev) pv_double <= pv_double + 1;
  end

  task automatic clear_track();
    samp_idx  = 0;
    pulse_cnt = 0;
    first_pv  = -1;
    last_pv   = -1;
  endtask

  // One sample: level high for two edges, then low; pulse observed 3 edges after capture.
  task automatic send_sample(input logic [15:0] s);
    bus.sample       = s;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    if (bus.period_valid) begin
      pulse_cnt++;
      if (first_pv < 0) first_pv = samp_idx;
      last_pv = samp_idx;
    end
    @(posedge clk); #1;
    samp_idx++;
  endtask

  function automatic logic [15:0] sq(input int i);
    return ((i % 20) < 10) ? HI : LO;
  endfunction

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample       = MIDSCALE;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    clear_track();
  endtask

  task automatic test_reset();
    do_reset();
    assertions++;
    if (bus.period_out !== 12'd0) begin
      failures++; $display("FAIL reset_period_out: got %0d expected 0", bus.period_out);
    end
    assertions++;
    if (bus.period_valid !== 1'b0) begin
      failures++; $display("FAIL reset_period_valid: got %b expected 0", bus.period_valid);
    end
    assertions++;
    if (bus.silent !== 1'b1) begin
      failures++; $display("FAIL reset_silent: got %b expected 1", bus.silent);
    end
  endtask

  task automatic test_square();
    do_reset();
    for (int i = 0; i < 200; i++) send_sample(sq(i));
    assertions++;
    if (pulse_cnt != 2) begin
      failures++; $display("FAIL square_pulses: got %0d expected 2", pulse_cnt);
    end
    assertions++;
    if (first_pv != 80) begin
      failures++; $display("FAIL square_first_idx: got %0d expected 80", first_pv);
    end
    assertions++;
    if (last_pv != 160) begin
      failures++; $display("FAIL square_second_idx: got %0d expected 160", last_pv);
    end
    assertions++;
    if (bus.period_out !== 12'd20) begin
      failures++; $display("FAIL square_period: got %0d expected 20", bus.period_out);
    end
    assertions++;
    if (bus.silent !== 1'b0) begin
      failures++; $display("FAIL square_silent: got %b expected 0", bus.silent);
    end
  endtask

  task automatic test_alternating();
    int per [4] = '{20, 21, 20, 21};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < per[p]; k++) send_sample((k < 10) ? HI : LO);
    end
    send_sample(HI);  // closing crossing at index 82
    assertions++;
    if (pulse_cnt != 1 || first_pv != 82) begin
      failures++;
      $display("FAIL alt_pulse: got %0d pulses at %0d expected 1 at 82", pulse_cnt, first_pv);
    end
    assertions++;
    if (bus.period_out !== 12'd21) begin
      failures++; $display("FAIL alt_period: got %0d expected 21", bus.period_out);
    end
  endtask

  task automatic test_noise();
    do_reset();
    for (int i = 0; i < 300; i++) send_sample(16'(32768 + ((i * 37) % 127) - 63));
    assertions++;
    if (pulse_cnt != 0) begin
      failures++; $display("FAIL noise_pulses: got %0d expected 0", pulse_cnt);
    end
    assertions++;
    if (bus.silent !== 1'b1) begin
      failures++; $display("FAIL noise_silent: got %b expected 1", bus.silent);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 200; i++) send_sample(((i % 20) == 3) ? SPIKE : sq(i));
    assertions++;
    if (pulse_cnt != 2 || first_pv != 80) begin
      failures++;
      $display("FAIL bounce_pulse: got %0d pulses first %0d expected 2 first 80",
               pulse_cnt, first_pv);
    end
    assertions++;
    if (bus.period_out !== 12'd20) begin
      failures++; $display("FAIL bounce_period: got %0d expected 20", bus.period_out);
    end
  endtask

  task automatic test_silence();
    do_reset();
    for (int i = 0; i < 100; i++) send_sample(sq(i));
    // Last crossing at index 80; saturation lands on index 80 + 4095.
    for (int i = 100; i < 4175; i++) send_sample(MIDSCALE);
    assertions++;
    if (bus.silent !== 1'b0) begin
      failures++; $display("FAIL silence_early: got %b expected 0", bus.silent);
    end
    send_sample(MIDSCALE);
    assertions++;
    if (bus.silent !== 1'b1) begin
      failures++; $display("FAIL silence_set: got %b expected 1", bus.silent);
    end
    clear_track();
    for (int i = 0; i < 81; i++) send_sample(sq(i));
    assertions++;
    if (pulse_cnt != 1 || first_pv != 80) begin
      failures++;
      $display("FAIL resume_pulse: got %0d pulses at %0d expected 1 at 80", pulse_cnt, first_pv);
    end
    assertions++;
    if (bus.silent !== 1'b0 || bus.period_out !== 12'd20) begin
      failures++;
      $display("FAIL resume_out: got silent %b period %0d expected 0 and 20",
               bus.silent, bus.period_out);
    end
  endtask

  task automatic test_held_valid();
    do_reset();
    bus.sample       = HI;
    bus.sample_valid = 1'b1;
    repeat (500) @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 samp_idx = 1;
    for (int i = 1; i < 81; i++) send_sample(sq(i));
    assertions++;
    if (pulse_cnt != 1 || first_pv != 80) begin
      failures++;
      $display("FAIL held_pulse: got %0d pulses at %0d expected 1 at 80", pulse_cnt, first_pv);
    end
    assertions++;
    if (bus.period_out !== 12'd20) begin
      failures++; $display("FAIL held_period: got %0d expected 20", bus.period_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 130; i++) send_sample(sq(i));
    assertions++;
    if (bus.period_out !== 12'd20 || bus.silent !== 1'b0) begin
      failures++;
      $display("FAIL premid_out: got period %0d silent %b expected 20 and 0",
               bus.period_out, bus.silent);
    end
    #2 reset_n = 1'b0;
    #1;
    assertions++;
    if (bus.period_out !== 12'd0 || bus.silent !== 1'b1 || bus.period_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got period %0d silent %b valid %b expected 0 1 0",
               bus.period_out, bus.silent, bus.period_valid);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    clear_track();
    for (int i = 0; i < 81; i++) send_sample(sq(i));
    assertions++;
    if (pulse_cnt != 1 || first_pv != 80) begin
      failures++;
      $display("FAIL postreset_pulse: got %0d pulses at %0d expected 1 at 80",
               pulse_cnt, first_pv);
    end
  endtask

  initial begin
    bus.sample       = MIDSCALE;
    bus.sample_valid = 1'b0;
    test_reset();
    test_square();
    test_alternating();
    test_noise();
    test_bounce();
    test_held_valid();
    test_reset_mid();
    test_silence();
    assertions++;
    if (pv_double != 0) begin
      failures++; $display("FAIL valid_back_to_back: got %0d expected 0", pv_double);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/pitch_period_detect.md
# pitch_period_detect

Measures the fundamental period of one guitar string's signal, in samples. It sits directly downstream of the 256x XADC oversampler and consumes its 16-bit `oversample` word and its `done` level. Per sample it removes the DC bias with a slow IIR baseline and finds rising zero-crossings with hysteresis. It averages four valid periods and emits one averaged period per group, plus a `silent` flag, to the note-matching logic.

## Interface
Parameters:
- `DC_SHIFT`, 8: IIR baseline time constant, 2^DC_SHIFT samples.
- `HYST`, 64: hysteresis half-width, in input LSBs.
- `MIN_PERIOD`, 8: crossings closer than this many samples are ignored.
- `MAX_PERIOD`, 4095: period saturation limit, and the silence threshold in samples.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample` in 16: unsigned oversampled ADC word; mid-scale is 16'h8000.
- `sample_valid` in 1: the upstream `done` level. A rising edge marks one new `sample`.
- `period_out` out 12: averaged period in samples. Reset value 0.
- `period_valid` out 1: one-cycle pulse when `period_out` updates. Reset value 0.
- `silent` out 1: high while no periodic signal is tracked. Reset value 1.

## Operation
- Edge detect: register `sample_valid`. A new sample is `sample_valid & ~q`. A level held for many cycles counts exactly once.
- Baseline: `base` is 16+DC_SHIFT bits wide and resets to 16'h8000 << DC_SHIFT.
  - Per sample: base += (sample − base_int) <<< 0, arithmetic, truncated.
  - `base_int` = base >> DC_SHIFT.
- AC value: ac = sample − base_int, 17-bit signed.
- Hysteresis latch `pol`, reset 0 (low):
  - Set when ac > +HYST.
  - Clear when ac < −HYST.
  - A rising crossing is a 0→1 transition of `pol`.
- Period counter `cnt`, 12 bits, saturating at MAX_PERIOD. Crossings at sample indices i and j give period j − i.
- FSM states ARMING (reset state), TRACKING.
  - ARMING, on a rising crossing: cnt←1, acc←0, n←0, go to TRACKING.
  - ARMING, on any other sample: no counting.
  - TRACKING, sample without a crossing: cnt←cnt+1.
  - TRACKING, reaching cnt==MAX_PERIOD: silent←1, acc←0, n←0, go to ARMING. This takes priority over a crossing on the same sample; that crossing is discarded.
  - TRACKING, crossing with cnt < MIN_PERIOD: treated as bounce. `cnt` keeps counting (+1), nothing is accumulated.
  - TRACKING, crossing with MIN_PERIOD ≤ cnt < MAX_PERIOD: acc += cnt, n += 1, cnt←1.
- Averaging: `acc` is 14 bits and `n` is 2 bits.
  - When the 4th valid period is accumulated: period_out←(acc_new + 2) >> 2, period_valid pulses, silent←0, acc←0, n←0.
- `silent` is set only by saturation or reset. It is cleared only by a completed average.
- `reset_n` low at any time clears all state to the reset values on the next evaluation, asynchronously. No partial average survives.

## Timing
- Stage 0: edge detect and `sample` capture, on the cycle the rising edge of `sample_valid` is seen.
- Stage 1: ac and baseline update.
- Stage 2: `pol`, FSM, counter and accumulator update. `period_valid`/`period_out` register here.
- Latency: 3 clk cycles from the `sample_valid` rising edge to `period_valid`.
- The block is always ready. The minimum spacing between new samples is 3 clk cycles; upstream provides ≥256 XADC conversions.
- `period_valid` is never high on two consecutive cycles.

## Structure
- The shared package `pitch_pkg` holds:
  - the FSM enum `pd_state_t` {ARMING, TRACKING};
  - the constants PERIOD_W=12, ACC_W=14, SAMPLE_W=16, MIDSCALE=16'h8000.
- One sub-module, `dc_tracker`, implements the baseline IIR and the ac subtraction, with DC_SHIFT as a parameter. The rest is top-level.

## Test plan
- Square wave of 0x8000±1000, period 20, 200 samples → first `period_valid` after 1 arming and 4 counted periods; period_out=20; silent=0. It repeats every 80 samples.
- Alternating periods 20, 21, 20, 21 → period_out=(82+2)>>2=21.
- Noise within ±63 of 0x8000 → no crossings; silent stays 1; `period_valid` never pulses.
- Square period 20 with a single-sample spike at +2000/−2000 (bounce, cnt<8) mid-period → period_out still 20.
- A tone, then a constant 0x8000 → silent=1 exactly MAX_PERIOD samples after the last crossing. A new tone resumes after arming.
- `sample_valid` held high for 500 cycles → exactly one sample is counted. `reset_n` pulsed low mid-average → outputs at reset values immediately; the next average needs a full 4 periods.
